// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk48 to a pixel strobe, runs h/v counters, decodes syncs/de/strobes.
// Latency: all outputs registered; they present the new position one clk48 after the advance decision.
// Backpressure: none; free-running. Optional frame counter port under VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0
) (
  input  logic        clk48,
  input  logic        rst_n,
  output logic        pix_stb,
  output logic [10:0] hpos,
  output logic [9:0]  vpos,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 8) begin : g_div_chk
    $error("vga_timing_gen: CLK_DIV must be 1..8");
  end

  localparam logic [2:0]  DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Decode bounds are one bit wider so an end bound equal to the total still fits.
  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [2:0]  div_q, div_d;
  logic [10:0] hpos_q, hpos_d;
  logic [9:0]  vpos_q, vpos_d;
  logic        de_q, de_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        stb_q, stb_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        adv;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic        hs_act, vs_act;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0]  fcnt_q, fcnt_d;
`endif

  // Next-state: divider, position counters and decode of the new position.
  always_comb begin
    adv    = (div_q == DIV_LAST);
    div_d  = adv ? 3'd0 : div_q + 3'd1;
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (adv) begin
      if (hpos_q == H_LAST) begin
        hpos_d = 11'd0;
        vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
      end else begin
        hpos_d = hpos_q + 11'd1;
      end
    end

    h_ext  = {1'b0, hpos_d};
    v_ext  = {1'b0, vpos_d};
    hs_act = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_act = (v_ext >= VS_BEG) && (v_ext < VS_END);

    // Decoded outputs only move on an advance so they always match hpos/vpos.
    de_d    = adv ? ((h_ext < H_ACT_W) && (v_ext < V_ACT_W)) : de_q;
    hsync_d = adv ? (hs_act ? HSYNC_POL : ~HSYNC_POL) : hsync_q;
    vsync_d = adv ? (vs_act ? VSYNC_POL : ~VSYNC_POL) : vsync_q;
    stb_d   = adv;
    ls_d    = adv && (hpos_d == 11'd0);
    fs_d    = adv && (hpos_d == 11'd0) && (vpos_d == 10'd0);

`ifdef VGA_FRAME_CNT_EN
    fcnt_d  = fs_d ? fcnt_q + 8'd1 : fcnt_q;
`endif
  end

  // State registers; synchronous reset parks the beam at the last position of the frame.
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      div_q   <= 3'd0;
      hpos_q  <= H_LAST;
      vpos_q  <= V_LAST;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      stb_q   <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q  <= 8'd0;
`endif
    end else begin
      div_q   <= div_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      stb_q   <= stb_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
`ifdef VGA_FRAME_CNT_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign pix_stb     = stb_q;
  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`ifdef VGA_FRAME_CNT_EN
  assign frame_cnt   = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster: u0 CLK_DIV=2 active-low syncs, u1 CLK_DIV=1 active-high hsync.
// Expected strobe positions are queued per instance; monitors pop on pix_stb and check holds in between.
// Frame counter checks are compiled in with VGA_FRAME_CNT_EN.
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    int h;
    int v;
    logic st;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
    int fc;
  } exp_t;

`ifdef VGA_FRAME_CNT_EN
  localparam int NFR = 257;
`else
  localparam int NFR = 3;
`endif

  logic clk48 = 1'b0;
  always #5 clk48 = ~clk48;

  logic        rst0_n, rst1_n;
  logic        stb0, de0, hs0, vs0, ls0, fs0;
  logic        stb1, de1, hs1, vs1, ls1, fs1;
  logic [10:0] hp0, hp1;
  logic [9:0]  vp0, vp1;
  logic [7:0]  fc0, fc1;
`ifndef VGA_FRAME_CNT_EN
  assign fc0 = 8'd0;
  assign fc1 = 8'd0;
`endif

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) u0 (
    .clk48(clk48), .rst_n(rst0_n), .pix_stb(stb0), .hpos(hp0), .vpos(vp0),
    .de(de0), .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) u1 (
    .clk48(clk48), .rst_n(rst1_n), .pix_stb(stb1), .hpos(hp1), .vpos(vp1),
    .de(de1), .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t last0, last1, hold0, hold1;
  int   cyc0, cyc1;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input exp_t e, input logic st, input logic [10:0] h,
                         input logic [9:0] v, input logic d, input logic hs, input logic vs,
                         input logic ls, input logic fs, input logic [7:0] fc);
    chk({tag, " pix_stb"},     32'(st), 32'(e.st));
    chk({tag, " hpos"},        32'(h),  e.h);
    chk({tag, " vpos"},        32'(v),  e.v);
    chk({tag, " de"},          32'(d),  32'(e.de));
    chk({tag, " hsync"},       32'(hs), 32'(e.hs));
    chk({tag, " vsync"},       32'(vs), 32'(e.vs));
    chk({tag, " line_start"},  32'(ls), 32'(e.ls));
    chk({tag, " frame_start"}, 32'(fs), 32'(e.fs));
`ifdef VGA_FRAME_CNT_EN
    chk({tag, " frame_cnt"},   32'(fc), e.fc);
`else
    if (fc !== 8'd0) chk({tag, " frame_cnt tie"}, 32'(fc), 32'd0);
`endif
  endtask

  // Reset image of the 16x8 raster: beam parked at (15,7), syncs inactive.
  function automatic exp_t rst_exp(input logic hpol);
    exp_t e;
    e.cyc = 0; e.h = 15; e.v = 7; e.st = 1'b0; e.de = 1'b0;
    e.hs = ~hpol; e.vs = 1'b1; e.ls = 1'b0; e.fs = 1'b0; e.fc = 0;
    return e;
  endfunction

  // Hand-derived strobe sequence: active 8x4, hsync at h 10..12, vsync at v 5..6,
  // first (0,0) strobe at cycle cdiv, one strobe every cdiv cycles.
  task automatic push_run(input int inst, input int cdiv, input logic hpol, input int nfr);
    exp_t e;
    int idx = 0;
    for (int f = 0; f < nfr; f++)
      for (int v = 0; v < 8; v++)
        for (int h = 0; h < 16; h++) begin
          e.cyc = cdiv * (1 + idx);
          e.h   = h;
          e.v   = v;
          e.st  = 1'b1;
          e.de  = (h < 8) && (v < 4);
          e.hs  = (h >= 10 && h <= 12) ? hpol : ~hpol;
          e.vs  = (v == 5 || v == 6) ? 1'b0 : 1'b1;
          e.ls  = (h == 0);
          e.fs  = (h == 0) && (v == 0);
          e.fc  = (f + 1) % 256;
          if (inst == 0) q0.push_back(e);
          else           q1.push_back(e);
          idx++;
        end
  endtask

  // u0 monitor: reset image while held, queued entry on each strobe, held values otherwise.
  always @(posedge clk48) begin
    #1;
    if (!rst0_n) begin
      cyc0  = 0;
      last0 = rst_exp(1'b0);
      chk_out("u0 reset", last0, stb0, hp0, vp0, de0, hs0, vs0, ls0, fs0, fc0);
    end else begin
      cyc0++;
      if (stb0) begin
        if (q0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u0 strobe: unexpected strobe at cycle %0d, expected none", cyc0);
        end else begin
          last0 = q0.pop_front();
          chk("u0 strobe cycle", cyc0, last0.cyc);
          chk_out("u0 strobe", last0, stb0, hp0, vp0, de0, hs0, vs0, ls0, fs0, fc0);
        end
      end else begin
        hold0 = last0; hold0.st = 1'b0; hold0.ls = 1'b0; hold0.fs = 1'b0;
        chk_out("u0 hold", hold0, stb0, hp0, vp0, de0, hs0, vs0, ls0, fs0, fc0);
      end
    end
  end

  // u1 monitor: same scheme; with CLK_DIV=1 every released cycle must carry a strobe.
  always @(posedge clk48) begin
    #1;
    if (!rst1_n) begin
      cyc1  = 0;
      last1 = rst_exp(1'b1);
      chk_out("u1 reset", last1, stb1, hp1, vp1, de1, hs1, vs1, ls1, fs1, fc1);
    end else begin
      cyc1++;
      if (stb1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u1 strobe: unexpected strobe at cycle %0d, expected none", cyc1);
        end else begin
          last1 = q1.pop_front();
          chk("u1 strobe cycle", cyc1, last1.cyc);
          chk_out("u1 strobe", last1, stb1, hp1, vp1, de1, hs1, vs1, ls1, fs1, fc1);
        end
      end else begin
        hold1 = last1; hold1.st = 1'b0; hold1.ls = 1'b0; hold1.fs = 1'b0;
        chk_out("u1 hold", hold1, stb1, hp1, vp1, de1, hs1, vs1, ls1, fs1, fc1);
      end
    end
  end

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk48);
    push_run(0, 2, 1'b0, 2);
    push_run(1, 1, 1'b1, 2);
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    fork
      begin : u1_flow
        for (int i = 0; i < 2000 && q1.size() != 0; i++) @(negedge clk48);
        if (q1.size() != 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u1 drain: %0d entries left, expected 0", q1.size());
        end
        rst1_n = 1'b0;
      end
      begin : u0_flow
        bit found;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
          @(negedge clk48);
          found = (hp0 == 11'd5) && (vp0 == 10'd2);
        end
        if (!found) begin
          n_cmp++; n_bad++;
          $display("FAIL u0 reach (5,2): got (%0d,%0d), expected (5,2)", hp0, vp0);
        end
        // One-cycle reset mid-frame, then the restart must repeat the first timing.
        q0.delete();
        rst0_n = 1'b0;
        @(negedge clk48);
        push_run(0, 2, 1'b0, NFR);
        rst0_n = 1'b1;
        for (int i = 0; i < NFR * 256 + 500 && q0.size() != 0; i++) @(negedge clk48);
        if (q0.size() != 0) begin
          n_cmp++; n_bad++;
          $display("FAIL u0 drain: %0d entries left, expected 0", q0.size());
        end
        rst0_n = 1'b0;
      end
    join

    repeat (2) @(negedge clk48);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator sitting directly upstream of the demo pixel pipeline (vgademo).
- Divides clk48 into a pixel strobe and runs horizontal/vertical position counters.
- Emits registered hsync/vsync/de plus beam position and line/frame strobes; the shader consumes these to produce R/G/B aligned with the syncs.
- Default timing is 640x480 raster, 800x525 totals, at 24 MHz pixel rate (CLK_DIV=2), giving about 57.1 Hz refresh.

Parameters:
- CLK_DIV, 2, clk48 cycles per pixel; legal 1..8.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- HSYNC_POL, 0, hsync active level.
- VSYNC_POL, 0, vsync active level.

Ports:
- clk48  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- pix_stb  out  1  one-clk48 pulse when a new pixel position is presented.
- hpos  out  11  current horizontal position, 0..H_TOTAL-1.
- vpos  out  10  current vertical position, 0..V_TOTAL-1.
- de  out  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE.
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL.
- vsync  out  1  vertical sync, polarity set by VSYNC_POL.
- line_start  out  1  pulse when hpos becomes 0.
- frame_start  out  1  pulse when (hpos,vpos) becomes (0,0).
- frame_cnt  out  8  frame counter; present only with VGA_FRAME_CNT_EN.

Behaviour:
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; elaboration error if H_TOTAL>2048 or V_TOTAL>1024.
- All outputs are flops. hpos, vpos, de, hsync, vsync and the strobes always describe the same position in the same clk48 cycle.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. The internal advance fires when div_cnt==CLK_DIV-1. CLK_DIV=1 means it fires every cycle.
- On advance, hpos increments. At H_TOTAL-1, hpos wraps to 0 and vpos increments; vpos wraps V_TOTAL-1 to 0.
- Outputs update in the clk48 cycle following the advance decision. pix_stb is high for exactly that one cycle.
- Decode, applied to the new position:
  - hsync is active iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC; it changes only with line advance, so it is aligned to hpos==0.
- line_start and frame_start are high for one clk48 cycle, coinciding with pix_stb, when the new position has hpos==0, or hpos==0 and vpos==0, respectively.
- Reset (rst_n low at a clk48 edge, taking priority over everything):
  - div_cnt=0, hpos=H_TOTAL-1, vpos=V_TOTAL-1.
  - de=0, hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - pix_stb, line_start and frame_start = 0.
- Reset mid-frame aborts immediately to the reset state; no partial line completes.
- After release:
  - First advance is on the CLK_DIV-th clock. Cycle 0 is the first clock with rst_n high; the advance is at cycle CLK_DIV-1.
  - Outputs show (0,0) at cycle CLK_DIV with de=1 and line_start=frame_start=pix_stb=1.
- Between strobes all outputs hold.

Optional Feature:
- Macro VGA_FRAME_CNT_EN.
- Defined: frame_cnt port exists, resets to 0, and increments (mod 256) on each entry to (0,0), in the same cycle frame_start is high. The first frame after reset reads 1.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Small config: H=8/2/3/3, V=4/1/2/1, CLK_DIV=2, both polarities 0. Release reset -> at cycle 2, hpos=0, vpos=0, de=1, frame_start=1, pix_stb=1; pix_stb thereafter every 2nd cycle.
- Same config, one full line -> de high for hpos 0..7; hsync=0 exactly at hpos 10..12; line_start once per 32 clk48 cycles.
- Full frame -> vsync=0 for vpos 5..6, i.e. 2*16=32 strobes; de=0 on all lines vpos>=4; frame_start period 256 clk48 cycles; vpos wraps 7 to 0.
- CLK_DIV=1, HSYNC_POL=1 -> pix_stb constantly 1 after release; hsync=1 only at hpos 10..12.
- Assert rst_n=0 for one cycle at hpos=5, vpos=2 -> next cycle shows reset values; restart timing identical to the first scenario. frame_cnt returns to 0 (VGA_FRAME_CNT_EN).
- VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt sequence 1,2,…,255,0,1.
